fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter OPC_HLT, default 4'hF, opcode field value that halts fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stall_i  input  1  hazard stall: hold PC, suppress instruction issue.
REQ-006 SHALL have port br_taken_i  input  1  branch redirect (decode-stage Flush), squashes the current fetch.
REQ-007 SHALL have port br_target_i  input  16  redirect PC, valid when br_taken_i=1.
REQ-008 SHALL have port icache_ready_i  input  1  I-cache data valid for icache_addr_o this cycle.
REQ-009 SHALL have port icache_data_i  input  16  I-cache instruction word.
REQ-010 SHALL have port icache_req_o  output  1  fetch request.
REQ-011 SHALL have port icache_addr_o  output  16  fetch address, equal to the PC register.
REQ-012 SHALL have port instr_o  output  16  instruction to IF/ID, equal to icache_data_i.
REQ-013 SHALL have port instr_valid_o  output  1  instr_o is to be captured by IF/ID this cycle.
REQ-014 SHALL have port pc_plus2_o  output  16  PC+2 of the issued instruction.
REQ-015 SHALL have port halted_o  output  1  fetch halted.
REQ-016 SHALL have port miss_cycles_o  output  16  saturating count of cycles spent in MISS.

Function
REQ-017 SHALL implement states FETCH, MISS, HALT; reset state FETCH.
REQ-018 In FETCH and MISS, icache_req_o SHALL be 1; in HALT it SHALL be 0.
REQ-019 Issue condition: state in {FETCH,MISS}, icache_ready_i=1, br_taken_i=0, redirect_pending=0, stall_i=0; instr_valid_o SHALL equal this condition, combinationally.
REQ-020 On issue of a non-HLT word, PC SHALL become PC+2 at the next edge (zero-bubble fetch).
REQ-021 On issue of a word with instr_o[15:12]=OPC_HLT, PC SHALL hold and state SHALL become HALT.
REQ-022 FETCH with icache_ready_i=0 and br_taken_i=0 -> MISS, PC held.
REQ-023 MISS with icache_ready_i=0 SHALL remain MISS and increment miss_cycles_o, saturating at 16'hFFFF.
REQ-024 br_taken_i=1 in FETCH, or in MISS with icache_ready_i=1, SHALL load PC with br_target_i, clear redirect_pending and go to FETCH; it has priority over stall_i and HLT.
REQ-025 br_taken_i=1 in MISS with icache_ready_i=0 SHALL set redirect_pending and latch br_target_i; state stays MISS.
REQ-026 MISS with icache_ready_i=1 and redirect_pending=1 SHALL discard the data (instr_valid_o=0), load PC with the latched target, clear redirect_pending, go to FETCH.
REQ-027 A second br_taken_i during MISS SHALL overwrite the latched target.
REQ-028 icache_ready_i=1 with stall_i=1 SHALL hold PC, go to FETCH, and re-request the same address.
REQ-029 HALT SHALL be sticky until rst; br_taken_i, stall_i and icache_ready_i SHALL be ignored there.
REQ-030 halted_o SHALL be 1 exactly when state=HALT.
REQ-031 pc_plus2_o SHALL be PC+2 modulo 2^16 (16'hFFFE wraps to 16'h0000), with no overflow flag.

Reset
REQ-032 While rst=1, at the edge: PC=RESET_PC, state=FETCH, redirect_pending=0, latched target=0, miss_cycles_o=0.
REQ-033 While rst=1, icache_req_o=0 and instr_valid_o=0, overriding all other inputs.
REQ-034 rst asserted mid-MISS or in HALT SHALL abandon the miss or halt with no pending state retained.

Structure
REQ-035 State encoding, OPC_HLT and 16-bit width constants SHALL live in the shared package wisc_pkg.
REQ-036 The PC+2 incrementer SHALL be an instance of the existing 16-bit add module (sub=0); no other sub-modules.

Verification
REQ-037 Reset with RESET_PC=16'h0000, always-ready cache -> addresses 0000, 0002, 0004 on consecutive cycles, instr_valid_o=1 each.
REQ-038 Cache not ready for 3 cycles at PC 16'h0010 -> instr_valid_o=0 for 3 cycles, miss_cycles_o=3, issue at 0010, then 0012.
REQ-039 br_taken_i=1 with target 16'h0100 during the 2nd MISS cycle, ready on the 4th -> data discarded, next address 0100, no issue from 0010.
REQ-040 stall_i=1 for 2 cycles at PC 16'h0020 -> address 0020 held, instr_valid_o=0; then issue at 0020 followed by 0022.
REQ-041 Fetch 16'hF000 at PC 16'h0030 -> one valid issue, halted_o=1 next cycle, icache_req_o=0; br_taken_i is ignored afterward; rst restores FETCH at 0000.
REQ-042 Fetch 16'hF000 with br_taken_i=1 and target 16'h0040 in the same cycle -> no halt, next address 0040.

Source files
------------

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wisc_pkg
// Description : Shared constants, state encoding and helpers for the WISC
//               fetch front end. Provides the 16-bit datapath width, opcode
//               field geometry, the default halt opcode and the fetch FSM
//               state type.
// Revision    : 1.0  initial release
// ============================================================================
package wisc_pkg;

    // Datapath width of PCs and instruction words.
    localparam int unsigned WORD_W = 16;

    // Opcode field lives in the top nibble of an instruction word.
    localparam int unsigned OPC_W = 4;

    // Default opcode that stops instruction fetch.
    localparam logic [OPC_W-1:0] OPC_HLT_DEF = 4'hF;

    // Instructions are 2 bytes wide; sequential fetch advances by this step.
    localparam logic [WORD_W-1:0] PC_STEP = 16'd2;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_MISS  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Extract the opcode field from an instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OPC_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_add.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_add
// Description : 16-bit adder/subtractor. sum_o = a_i + b_i when sub_i = 0,
//               a_i - b_i when sub_i = 1. Result wraps modulo 2^16; no carry
//               or overflow is reported.
// Ports       : a_i   [15:0] in   first operand
//               b_i   [15:0] in   second operand
//               sub_i        in   1 = subtract b_i, 0 = add b_i
//               sum_o [15:0] out  result
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl_add
    import wisc_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              sub_i,
    output logic [WORD_W-1:0] sum_o
);

    logic [WORD_W-1:0] b_eff;
    logic [WORD_W-1:0] cin_w;

    // Two's-complement subtract: invert b and inject a carry-in of 1.
    assign b_eff = b_i ^ {WORD_W{sub_i}};
    assign cin_w = {{(WORD_W-1){1'b0}}, sub_i};
    assign sum_o = a_i + b_eff + cin_w;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Holds the PC, requests words
//               from the I-cache, issues them to IF/ID, tracks cache misses,
//               handles branch redirects (including redirects that arrive
//               while a miss is outstanding), hazard stalls and the HLT
//               instruction.
// Ports       : clk                in   clock, rising edge
//               rst                in   synchronous active-high reset
//               stall_i            in   hold PC, suppress issue
//               br_taken_i         in   branch redirect, squashes fetch
//               br_target_i [15:0] in   redirect PC
//               icache_ready_i     in   I-cache data valid this cycle
//               icache_data_i[15:0]in   I-cache instruction word
//               icache_req_o       out  fetch request
//               icache_addr_o[15:0]out  fetch address (PC register)
//               instr_o     [15:0] out  instruction to IF/ID
//               instr_valid_o      out  IF/ID capture enable
//               pc_plus2_o  [15:0] out  PC + 2 of issued instruction
//               halted_o           out  fetch halted
//               miss_cycles_o[15:0]out  saturating miss cycle count
// Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
    import wisc_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [OPC_W-1:0]  OPC_HLT  = OPC_HLT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [WORD_W-1:0] br_target_i,
    input  logic              icache_ready_i,
    input  logic [WORD_W-1:0] icache_data_i,
    output logic              icache_req_o,
    output logic [WORD_W-1:0] icache_addr_o,
    output logic [WORD_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic [WORD_W-1:0] pc_plus2_o,
    output logic              halted_o,
    output logic [WORD_W-1:0] miss_cycles_o
);

    fetch_state_e      state_q;
    logic [WORD_W-1:0] pc_q;
    logic              redir_pend_q;
    logic [WORD_W-1:0] redir_tgt_q;
    logic [WORD_W-1:0] miss_cnt_q;

    logic [WORD_W-1:0] pc_plus2_d;
    logic [WORD_W-1:0] miss_cnt_d;
    logic              active_w;
    logic              issue_w;
    logic              is_hlt_w;

    // ------------------------------------------------------------------
    // PC + 2 incrementer
    // ------------------------------------------------------------------
    fetch_ctrl_add u_pc_inc (
        .a_i   (pc_q),
        .b_i   (PC_STEP),
        .sub_i (1'b0),
        .sum_o (pc_plus2_d)
    );

    // Saturating miss counter increment.
    assign miss_cnt_d = (miss_cnt_q == {WORD_W{1'b1}}) ? miss_cnt_q
                                                       : miss_cnt_q + 16'd1;

    // Fetch is active in FETCH and MISS; reset forces everything quiet.
    assign active_w = !rst && (state_q != ST_HALT);

    // A word is issued only when it is valid and nothing is squashing it.
    // A pending redirect means the returning word belongs to the wrong path.
    assign issue_w  = active_w && icache_ready_i && !br_taken_i
                      && !redir_pend_q && !stall_i;

    assign is_hlt_w = (opcode_of(icache_data_i) == OPC_HLT);

    assign icache_req_o  = active_w;
    assign icache_addr_o = pc_q;
    assign instr_o       = icache_data_i;
    assign instr_valid_o = issue_w;
    assign pc_plus2_o    = pc_plus2_d;
    assign halted_o      = (state_q == ST_HALT);
    assign miss_cycles_o = miss_cnt_q;

    // ------------------------------------------------------------------
    // Fetch FSM and PC register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
            miss_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH, ST_MISS: begin
                    if (br_taken_i && (state_q == ST_FETCH || icache_ready_i)) begin
                        // Redirect can take effect immediately.
                        pc_q         <= br_target_i;
                        redir_pend_q <= 1'b0;
                        state_q      <= ST_FETCH;
                    end else if (br_taken_i) begin
                        // Miss still outstanding: remember the newest target
                        // and drop the in-flight word when it finally arrives.
                        redir_pend_q <= 1'b1;
                        redir_tgt_q  <= br_target_i;
                        miss_cnt_q   <= miss_cnt_d;
                        state_q      <= ST_MISS;
                    end else if (!icache_ready_i) begin
                        // Every request cycle without data counts as a miss
                        // cycle, including the one that enters MISS.
                        miss_cnt_q <= miss_cnt_d;
                        state_q    <= ST_MISS;
                    end else if (redir_pend_q) begin
                        pc_q         <= redir_tgt_q;
                        redir_pend_q <= 1'b0;
                        state_q      <= ST_FETCH;
                    end else if (stall_i) begin
                        // Data is dropped; the same address is re-requested.
                        state_q <= ST_FETCH;
                    end else if (is_hlt_w) begin
                        state_q <= ST_HALT;
                    end else begin
                        pc_q    <= pc_plus2_d;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    // HALT is sticky until reset; the unused encoding also
                    // parks here so the FSM cannot wander.
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        br_taken_i;
    logic [15:0] br_target_i;
    logic        icache_ready_i;
    logic [15:0] icache_data_i;
    logic        icache_req_o;
    logic [15:0] icache_addr_o;
    logic [15:0] instr_o;
    logic        instr_valid_o;
    logic [15:0] pc_plus2_o;
    logic        halted_o;
    logic [15:0] miss_cycles_o;

    int n_cmp;
    int n_err;

    fetch_ctrl #(
        .RESET_PC (16'h0000),
        .OPC_HLT  (4'hF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .br_taken_i     (br_taken_i),
        .br_target_i    (br_target_i),
        .icache_ready_i (icache_ready_i),
        .icache_data_i  (icache_data_i),
        .icache_req_o   (icache_req_o),
        .icache_addr_o  (icache_addr_o),
        .instr_o        (instr_o),
        .instr_valid_o  (instr_valid_o),
        .pc_plus2_o     (pc_plus2_o),
        .halted_o       (halted_o),
        .miss_cycles_o  (miss_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs and let combinational outputs settle.
    task automatic drv(input logic rdy, input logic [15:0] data,
                       input logic br, input logic [15:0] tgt, input logic stl);
        icache_ready_i = rdy;
        icache_data_i  = data;
        br_taken_i     = br;
        br_target_i    = tgt;
        stall_i        = stl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        drv(1'b1, 16'h1000, 1'b1, 16'h0055, 1'b0);
        n_cmp++; if (icache_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", icache_req_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", icache_addr_o); end
        n_cmp++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", halted_o); end
        n_cmp++; if (miss_cycles_o !== 16'h0000) begin n_err++; $display("FAIL rst_miss: got %h want 0000", miss_cycles_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL rst_addr_br_ignored: got %h want 0000", icache_addr_o); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_req_o !== 1'b1) begin n_err++; $display("FAIL seq_req: got %b want 1", icache_req_o); end
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL seq_addr0: got %h want 0000", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid0: got %b want 1", instr_valid_o); end
        n_cmp++; if (pc_plus2_o !== 16'h0002) begin n_err++; $display("FAIL seq_pc2: got %h want 0002", pc_plus2_o); end
        n_cmp++; if (instr_o !== 16'h1000) begin n_err++; $display("FAIL seq_instr: got %h want 1000", instr_o); end
        tick();
        drv(1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_addr_o !== 16'h0002) begin n_err++; $display("FAIL seq_addr1: got %h want 0002", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid1: got %b want 1", instr_valid_o); end
        tick();
        drv(1'b1, 16'h2000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_addr_o !== 16'h0004) begin n_err++; $display("FAIL seq_addr2: got %h want 0004", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid2: got %b want 1", instr_valid_o); end
        tick();
        drv(1'b1, 16'h1000, 1'b1, 16'h0010, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL br_squash: got %b want 0", instr_valid_o); end
        tick();
    endtask

    task automatic test_miss();
        drv(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_addr_o !== 16'h0010) begin n_err++; $display("FAIL miss_addr: got %h want 0010", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL miss_valid_c1: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL miss_valid_c2: got %b want 0", instr_valid_o); end
        n_cmp++; if (icache_req_o !== 1'b1) begin n_err++; $display("FAIL miss_req: got %b want 1", icache_req_o); end
        tick();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL miss_valid_c3: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (miss_cycles_o !== 16'd3) begin n_err++; $display("FAIL miss_count3: got %0d want 3", miss_cycles_o); end
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL miss_issue: got %b want 1", instr_valid_o); end
        n_cmp++; if (icache_addr_o !== 16'h0010) begin n_err++; $display("FAIL miss_issue_addr: got %h want 0010", icache_addr_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0012) begin n_err++; $display("FAIL miss_next_addr: got %h want 0012", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL miss_next_valid: got %b want 1", instr_valid_o); end
        n_cmp++; if (miss_cycles_o !== 16'd3) begin n_err++; $display("FAIL miss_count_hold: got %0d want 3", miss_cycles_o); end
        drv(1'b1, 16'h1000, 1'b1, 16'h0010, 1'b0);
        tick();
    endtask

    task automatic test_redirect_in_miss();
        drv(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
        tick();
        drv(1'b0, 16'h1000, 1'b1, 16'h0100, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdm_valid_br: got %b want 0", instr_valid_o); end
        tick();
        drv(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_addr_o !== 16'h0010) begin n_err++; $display("FAIL rdm_addr_hold: got %h want 0010", icache_addr_o); end
        tick();
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rdm_discard: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0100) begin n_err++; $display("FAIL rdm_target: got %h want 0100", icache_addr_o); end
        n_cmp++; if (miss_cycles_o !== 16'd6) begin n_err++; $display("FAIL rdm_count: got %0d want 6", miss_cycles_o); end
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL rdm_issue: got %b want 1", instr_valid_o); end
    endtask

    task automatic test_overwrite();
        drv(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
        tick();
        drv(1'b0, 16'h1000, 1'b1, 16'h0300, 1'b0);
        tick();
        drv(1'b0, 16'h1000, 1'b1, 16'h0020, 1'b0);
        tick();
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL ovw_discard: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0020) begin n_err++; $display("FAIL ovw_target: got %h want 0020", icache_addr_o); end
        n_cmp++; if (miss_cycles_o !== 16'd9) begin n_err++; $display("FAIL ovw_count: got %0d want 9", miss_cycles_o); end
    endtask

    task automatic test_stall();
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_valid_c1: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0020) begin n_err++; $display("FAIL stall_addr_c2: got %h want 0020", icache_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_valid_c2: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0020) begin n_err++; $display("FAIL stall_addr_end: got %h want 0020", icache_addr_o); end
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stall_issue: got %b want 1", instr_valid_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0022) begin n_err++; $display("FAIL stall_next: got %h want 0022", icache_addr_o); end
        drv(1'b1, 16'h1000, 1'b1, 16'h0030, 1'b0);
        tick();
    endtask

    task automatic test_halt();
        drv(1'b1, 16'hF000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL hlt_issue: got %b want 1", instr_valid_o); end
        n_cmp++; if (icache_addr_o !== 16'h0030) begin n_err++; $display("FAIL hlt_addr: got %h want 0030", icache_addr_o); end
        tick();
        drv(1'b1, 16'h1000, 1'b1, 16'h0500, 1'b0);
        n_cmp++; if (halted_o !== 1'b1) begin n_err++; $display("FAIL hlt_halted: got %b want 1", halted_o); end
        n_cmp++; if (icache_req_o !== 1'b0) begin n_err++; $display("FAIL hlt_req: got %b want 0", icache_req_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL hlt_valid: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (halted_o !== 1'b1) begin n_err++; $display("FAIL hlt_sticky: got %b want 1", halted_o); end
        n_cmp++; if (icache_addr_o !== 16'h0030) begin n_err++; $display("FAIL hlt_br_ignored: got %h want 0030", icache_addr_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL hlt_rst_halted: got %b want 0", halted_o); end
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL hlt_rst_addr: got %h want 0000", icache_addr_o); end
        n_cmp++; if (miss_cycles_o !== 16'h0000) begin n_err++; $display("FAIL hlt_rst_miss: got %h want 0000", miss_cycles_o); end
        n_cmp++; if (icache_req_o !== 1'b1) begin n_err++; $display("FAIL hlt_rst_req: got %b want 1", icache_req_o); end
    endtask

    task automatic test_hlt_with_branch();
        drv(1'b1, 16'hF000, 1'b1, 16'h0040, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL hltbr_valid: got %b want 0", instr_valid_o); end
        tick();
        n_cmp++; if (halted_o !== 1'b0) begin n_err++; $display("FAIL hltbr_halted: got %b want 0", halted_o); end
        n_cmp++; if (icache_addr_o !== 16'h0040) begin n_err++; $display("FAIL hltbr_addr: got %h want 0040", icache_addr_o); end
        n_cmp++; if (icache_req_o !== 1'b1) begin n_err++; $display("FAIL hltbr_req: got %b want 1", icache_req_o); end
    endtask

    task automatic test_wrap();
        drv(1'b1, 16'h1000, 1'b1, 16'hFFFE, 1'b0);
        tick();
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_addr_o !== 16'hFFFE) begin n_err++; $display("FAIL wrap_addr: got %h want fffe", icache_addr_o); end
        n_cmp++; if (pc_plus2_o !== 16'h0000) begin n_err++; $display("FAIL wrap_pc2: got %h want 0000", pc_plus2_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL wrap_next: got %h want 0000", icache_addr_o); end
    endtask

    task automatic test_rst_mid_miss();
        drv(1'b1, 16'h1000, 1'b1, 16'h0060, 1'b0);
        tick();
        drv(1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
        tick();
        drv(1'b0, 16'h1000, 1'b1, 16'h0700, 1'b0);
        tick();
        rst = 1'b1;
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (icache_req_o !== 1'b0) begin n_err++; $display("FAIL rmm_req: got %b want 0", icache_req_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rmm_valid: got %b want 0", instr_valid_o); end
        tick();
        rst = 1'b0;
        drv(1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0);
        n_cmp++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL rmm_issue: got %b want 1", instr_valid_o); end
        n_cmp++; if (icache_addr_o !== 16'h0000) begin n_err++; $display("FAIL rmm_addr: got %h want 0000", icache_addr_o); end
        n_cmp++; if (miss_cycles_o !== 16'h0000) begin n_err++; $display("FAIL rmm_miss: got %h want 0000", miss_cycles_o); end
        tick();
        n_cmp++; if (icache_addr_o !== 16'h0002) begin n_err++; $display("FAIL rmm_no_stale: got %h want 0002", icache_addr_o); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        stall_i = 1'b0;
        br_taken_i = 1'b0;
        br_target_i = 16'h0000;
        icache_ready_i = 1'b0;
        icache_data_i = 16'h0000;

        test_reset();
        test_sequential();
        test_miss();
        test_redirect_in_miss();
        test_overwrite();
        test_stall();
        test_halt();
        test_hlt_with_branch();
        test_wrap();
        test_rst_mid_miss();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
